// File: rtl/fp_muldiv_ctrl.sv
// IEEE754 single-precision multiply/divide front end for the shared CORDIC mantissa unit.
// Special operands are resolved locally. Normal operands go through the CORDIC and are packed here.
module fp_muldiv_ctrl #(
   parameter int TIMEOUT_CYC = 40
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_op,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic        res_vld,
   output logic [31:0] result,
   output logic [4:0]  flags,
   output logic [23:0] mul_data1_out,
   output logic [23:0] mul_data2_out,
   output logic [23:0] div_data1_out,
   output logic [23:0] div_data2_out,
   output logic        mul_trig,
   output logic        div_trig,
   input  logic [22:0] cu_data_in,
   input  logic [1:0]  cu_other_in,
   input  logic        cu_vld
);
   localparam int CntW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [31:0] QNAN = 32'h7FC00000;

   typedef enum logic [2:0] {IDLE, DECODE, WAIT, PACK, DONE} state_t;

   state_t          state_q, state_d;
   logic [31:0]     a_q, a_d, b_q, b_d;
   logic            op_q, op_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [22:0]     cuFrac_q, cuFrac_d;
   logic [1:0]      cuOther_q, cuOther_d;
   logic [31:0]     result_q, result_d;
   logic [4:0]      flags_q, flags_d;
   logic            resVld_q, resVld_d;
   logic            mulTrig_q, mulTrig_d, divTrig_q, divTrig_d;
   logic [23:0]     mul1_q, mul1_d, mul2_q, mul2_d, div1_q, div1_d, div2_q, div2_d;

   logic              sign;
   logic signed [9:0] expA, expB, expRes;

   function automatic logic isZero(input logic [31:0] x);
      return x[30:23] == 8'h00;
   endfunction

   function automatic logic isInf(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
   endfunction

   function automatic logic isNaN(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   function automatic logic isNormal(input logic [31:0] x);
      return (x[30:23] != 8'h00) && (x[30:23] != 8'hFF);
   endfunction

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= 1'b0;
         cnt_q     <= '0;
         cuFrac_q  <= '0;
         cuOther_q <= '0;
         result_q  <= '0;
         flags_q   <= '0;
         resVld_q  <= 1'b0;
         mulTrig_q <= 1'b0;
         divTrig_q <= 1'b0;
         mul1_q    <= '0;
         mul2_q    <= '0;
         div1_q    <= '0;
         div2_q    <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         cuFrac_q  <= cuFrac_d;
         cuOther_q <= cuOther_d;
         result_q  <= result_d;
         flags_q   <= flags_d;
         resVld_q  <= resVld_d;
         mulTrig_q <= mulTrig_d;
         divTrig_q <= divTrig_d;
         mul1_q    <= mul1_d;
         mul2_q    <= mul2_d;
         div1_q    <= div1_d;
         div2_q    <= div2_d;
      end
   end

   // Triggers and mantissas are registered at acceptance so they are valid together in DECODE.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      cuFrac_d  = cuFrac_q;
      cuOther_d = cuOther_q;
      result_d  = result_q;
      flags_d   = flags_q;
      mulTrig_d = 1'b0;
      divTrig_d = 1'b0;
      mul1_d    = mul1_q;
      mul2_d    = mul2_q;
      div1_d    = div1_q;
      div2_d    = div2_q;
      sign      = a_q[31] ^ b_q[31];
      expA      = $signed({2'b00, a_q[30:23]});
      expB      = $signed({2'b00, b_q[30:23]});
      if (op_q)
         expRes = expA - expB + 10'sd127 - $signed({9'd0, cuOther_q[0]});
      else
         expRes = expA + expB - 10'sd127 + $signed({9'd0, cuOther_q[0]});

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               a_d     = a_in;
               b_d     = b_in;
               op_d    = req_op;
               state_d = DECODE;
               mul1_d  = '0;
               mul2_d  = '0;
               div1_d  = '0;
               div2_d  = '0;
               if (isNormal(a_in) && isNormal(b_in)) begin
                  if (req_op) begin
                     divTrig_d = 1'b1;
                     div1_d    = {1'b1, a_in[22:0]};
                     div2_d    = {1'b1, b_in[22:0]};
                  end else begin
                     mulTrig_d = 1'b1;
                     mul1_d    = {1'b1, a_in[22:0]};
                     mul2_d    = {1'b1, b_in[22:0]};
                  end
               end
            end
         end
         DECODE: begin
            if (isNormal(a_q) && isNormal(b_q)) begin
               cnt_d   = '0;
               state_d = WAIT;
            end else begin
               state_d  = DONE;
               flags_d  = 5'b00000;
               result_d = {sign, 31'd0};
               if (isNaN(a_q) || isNaN(b_q)) begin
                  result_d = QNAN;
               end else if (!op_q) begin
                  if ((isZero(a_q) && isInf(b_q)) || (isInf(a_q) && isZero(b_q))) begin
                     result_d = QNAN;
                     flags_d  = 5'b01000;
                  end else if (isInf(a_q) || isInf(b_q)) begin
                     result_d = {sign, 8'hFF, 23'd0};
                  end
               end else begin
                  if ((isZero(a_q) && isZero(b_q)) || (isInf(a_q) && isInf(b_q))) begin
                     result_d = QNAN;
                     flags_d  = 5'b01000;
                  end else if (isZero(b_q)) begin
                     result_d = {sign, 8'hFF, 23'd0};
                     flags_d  = 5'b00100;
                  end else if (!(isZero(a_q) || isInf(b_q))) begin
                     result_d = {sign, 8'hFF, 23'd0};
                  end
               end
            end
         end
         WAIT: begin
            if (cu_vld) begin
               cuFrac_d  = cu_data_in;
               cuOther_d = cu_other_in;
               state_d   = PACK;
            end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
               result_d = QNAN;
               flags_d  = 5'b10000;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PACK: begin
            state_d = DONE;
            if (cuOther_q[1]) begin
               result_d = {sign, 31'd0};
               flags_d  = 5'b00000;
            end else if (expRes >= 10'sd255) begin
               result_d = {sign, 8'hFF, 23'd0};
               flags_d  = 5'b00010;
            end else if (expRes <= 10'sd0) begin
               result_d = {sign, 31'd0};
               flags_d  = 5'b00001;
            end else begin
               result_d = {sign, expRes[7:0], cuFrac_q};
               flags_d  = 5'b00000;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      resVld_d = (state_d == DONE);
   end

   assign req_ready     = (state_q == IDLE);
   assign res_vld       = resVld_q;
   assign result        = result_q;
   assign flags         = flags_q;
   assign mul_trig      = mulTrig_q;
   assign div_trig      = divTrig_q;
   assign mul_data1_out = mul1_q;
   assign mul_data2_out = mul2_q;
   assign div_data1_out = div1_q;
   assign div_data2_out = div2_q;

endmodule

// File: tb/tb_fp_muldiv_ctrl.sv
// Scoreboard bench for fp_muldiv_ctrl: a driver pushes expected results, a monitor pops and compares,
// and a CORDIC responder answers triggers using plain integer mantissa arithmetic.
module tb_fp_muldiv_ctrl;
   localparam int TIMEOUT_CYC = 40;
   localparam logic [31:0] QNAN = 32'h7FC00000;

   logic        sysClk, sysRstN, reqValid, reqReady, reqOp;
   logic [31:0] aIn, bIn, result;
   logic        resVld, mulTrig, divTrig, cuVld;
   logic [4:0]  flags;
   logic [23:0] mulData1, mulData2, divData1, divData2;
   logic [22:0] cuData;
   logic [1:0]  cuOther;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  flg;
      int          cyc;
      bit          viaCordic;
   } expT;

   typedef struct {
      int          cyc;
      bit          op;
      logic [23:0] m1;
      logic [23:0] m2;
   } trigT;

   expT  expQ[$];
   trigT trigQ[$];
   int   vldCycQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   respMode = 0;
   int   strayCnt = 0;

   fp_muldiv_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .sys_clk(sysClk),
      .sys_rst_n(sysRstN),
      .req_valid(reqValid),
      .req_ready(reqReady),
      .req_op(reqOp),
      .a_in(aIn),
      .b_in(bIn),
      .res_vld(resVld),
      .result(result),
      .flags(flags),
      .mul_data1_out(mulData1),
      .mul_data2_out(mulData2),
      .div_data1_out(divData1),
      .div_data2_out(divData2),
      .mul_trig(mulTrig),
      .div_trig(divTrig),
      .cu_data_in(cuData),
      .cu_other_in(cuOther),
      .cu_vld(cuVld)
   );

   // Free-running clock and a cycle counter used to time-stamp events.
   initial sysClk = 1'b0;
   always #5 sysClk = ~sysClk;
   always @(posedge sysClk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: event not allowed here (t=%0t)", name, $time);
   endtask

   function automatic bit fIsZero(input logic [31:0] x);
      return x[30:23] == 8'd0;
   endfunction
   function automatic bit fIsInf(input logic [31:0] x);
      return x[30:23] == 8'd255 && x[22:0] == 23'd0;
   endfunction
   function automatic bit fIsNaN(input logic [31:0] x);
      return x[30:23] == 8'd255 && x[22:0] != 23'd0;
   endfunction
   function automatic bit fIsNormal(input logic [31:0] x);
      return !fIsZero(x) && x[30:23] != 8'd255;
   endfunction

   // Ideal truncating mantissa unit: returns {exp_flag, fraction}.
   function automatic logic [23:0] cordicModel(input bit op, input logic [23:0] m1, input logic [23:0] m2);
      longint unsigned p;
      if (!op) begin
         p = 64'(m1) * 64'(m2);
         if (p >= (64'd1 << 47)) return {1'b1, p[46:24]};
         return {1'b0, p[45:23]};
      end
      if (m1 >= m2) begin
         p = (64'(m1) << 23) / 64'(m2);
         return {1'b0, p[22:0]};
      end
      p = (64'(m1) << 24) / 64'(m2);
      return {1'b1, p[22:0]};
   endfunction

   function automatic expT refModel(input bit op, input logic [31:0] a, input logic [31:0] b,
                                    input int mode, input int acc);
      expT         e;
      logic        s;
      logic [23:0] cu;
      int          ex;
      s           = a[31] ^ b[31];
      e.cyc       = acc + 1;
      e.viaCordic = 0;
      e.flg       = 5'b00000;
      e.res       = {s, 31'd0};
      if (fIsNaN(a) || fIsNaN(b)) e.res = QNAN;
      else if (!op && ((fIsZero(a) && fIsInf(b)) || (fIsInf(a) && fIsZero(b)))) begin
         e.res = QNAN; e.flg = 5'b01000;
      end else if (!op && (fIsInf(a) || fIsInf(b))) e.res = {s, 8'hFF, 23'd0};
      else if (!op && (fIsZero(a) || fIsZero(b))) e.res = {s, 31'd0};
      else if (op && ((fIsZero(a) && fIsZero(b)) || (fIsInf(a) && fIsInf(b)))) begin
         e.res = QNAN; e.flg = 5'b01000;
      end else if (op && fIsZero(b)) begin
         e.res = {s, 8'hFF, 23'd0}; e.flg = 5'b00100;
      end else if (op && (fIsZero(a) || fIsInf(b))) e.res = {s, 31'd0};
      else if (op && fIsInf(a)) e.res = {s, 8'hFF, 23'd0};
      else if (mode == 2) begin
         e.res = QNAN; e.flg = 5'b10000; e.cyc = acc + 1 + TIMEOUT_CYC;
      end else begin
         e.viaCordic = 1;
         cu = cordicModel(op, {1'b1, a[22:0]}, {1'b1, b[22:0]});
         if (op) ex = int'(a[30:23]) - int'(b[30:23]) + 127 - int'(cu[23]);
         else    ex = int'(a[30:23]) + int'(b[30:23]) - 127 + int'(cu[23]);
         if (mode == 1)      e.res = {s, 31'd0};
         else if (ex >= 255) begin e.res = {s, 8'hFF, 23'd0}; e.flg = 5'b00010; end
         else if (ex <= 0)   begin e.res = {s, 31'd0};        e.flg = 5'b00001; end
         else                e.res = {s, 8'(ex), cu[22:0]};
      end
      return e;
   endfunction

   function automatic logic [31:0] randOperand();
      logic [31:0] x;
      int r;
      r = $urandom_range(0, 9);
      x = $urandom;
      case (r)
         0: x[30:0] = 31'd0;
         1: x[30:23] = 8'd0;
         2: x[30:0] = {8'hFF, 23'd0};
         3: begin x[30:23] = 8'hFF; x[22] = 1'b1; end
         default: x[30:23] = 8'($urandom_range(1, 254));
      endcase
      return x;
   endfunction

   task automatic applyStimulus(input bit op, input logic [31:0] a, input logic [31:0] b);
      int   w;
      int   acc;
      trigT t;
      @(negedge sysClk);
      reqOp = op; aIn = a; bIn = b; reqValid = 1'b1;
      w = 0;
      while (!reqReady && w < 200) begin
         @(negedge sysClk);
         w++;
      end
      if (!reqReady) begin
         failNow("req_ready_timeout");
         reqValid = 1'b0;
         return;
      end
      @(posedge sysClk);
      #1;
      acc = cyc;
      reqValid = 1'b0;
      if (fIsNormal(a) && fIsNormal(b)) begin
         t.cyc = acc; t.op = op; t.m1 = {1'b1, a[22:0]}; t.m2 = {1'b1, b[22:0]};
         trigQ.push_back(t);
      end
      expQ.push_back(refModel(op, a, b, respMode, acc));
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 300) begin
         @(negedge sysClk);
         n++;
      end
      if (expQ.size() != 0) begin
         failNow("drain_timeout");
         expQ.delete();
      end
      repeat (2) @(negedge sysClk);
   endtask

   task automatic checkResetState();
      checkOutput("rst_req_ready", 32'(reqReady), 32'd1);
      checkOutput("rst_res_vld", 32'(resVld), 32'd0);
      checkOutput("rst_result", result, 32'd0);
      checkOutput("rst_flags", 32'(flags), 32'd0);
      checkOutput("rst_triggers", 32'({mulTrig, divTrig}), 32'd0);
      checkOutput("rst_data", 32'(mulData1 | mulData2 | divData1 | divData2), 32'd0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT issues a trigger or a result.
   initial begin : monitor
      expT  e;
      trigT t;
      int   want;
      forever begin
         @(negedge sysClk);
         if (sysRstN && (mulTrig || divTrig)) begin
            if (trigQ.size() == 0) failNow("spurious_trigger");
            else begin
               t = trigQ.pop_front();
               checkOutput("trigger_cycle", cyc, t.cyc);
               checkOutput("trigger_kind", 32'({mulTrig, divTrig}), t.op ? 32'd1 : 32'd2);
               checkOutput("data1", t.op ? 32'(divData1) : 32'(mulData1), 32'(t.m1));
               checkOutput("data2", t.op ? 32'(divData2) : 32'(mulData2), 32'(t.m2));
               checkOutput("unused_pair", t.op ? 32'(mulData1 | mulData2) : 32'(divData1 | divData2), 32'd0);
            end
         end
         if (sysRstN && resVld) begin
            if (expQ.size() == 0) failNow("unexpected_res_vld");
            else begin
               e = expQ.pop_front();
               checkOutput("result", result, e.res);
               checkOutput("flags", 32'(flags), 32'(e.flg));
               want = e.cyc;
               if (e.viaCordic) begin
                  if (vldCycQ.size() == 0) begin
                     failNow("missing_cu_vld");
                     want = cyc;
                  end else want = vldCycQ.pop_front() + 2;
               end
               checkOutput("res_latency", cyc, want);
            end
         end
      end
   end

   // CORDIC responder: answers triggers after a random delay, and emits stray vld pulses on request.
   initial begin : responder
      bit          rOp;
      logic [23:0] rCu;
      int          strayDone;
      strayDone = 0;
      cuVld = 1'b0; cuData = '0; cuOther = '0;
      forever begin
         @(negedge sysClk);
         if (strayCnt != strayDone) begin
            strayDone++;
            cuData = 23'($urandom); cuOther = 2'($urandom); cuVld = 1'b1;
            @(negedge sysClk);
            cuVld = 1'b0;
         end else if (sysRstN && (mulTrig || divTrig) && respMode != 2) begin
            rOp = divTrig;
            rCu = rOp ? cordicModel(1'b1, divData1, divData2) : cordicModel(1'b0, mulData1, mulData2);
            repeat ($urandom_range(1, 5)) @(negedge sysClk);
            cuData  = rCu[22:0];
            cuOther = {respMode == 1, rCu[23]};
            cuVld   = 1'b1;
            vldCycQ.push_back(cyc);
            @(negedge sysClk);
            cuVld  = 1'b0;
            cuData = 23'($urandom);
         end
      end
   end

   initial begin : driver
      sysRstN = 1'b0; reqValid = 1'b0; reqOp = 1'b0; aIn = '0; bIn = '0;
      repeat (3) @(negedge sysClk);
      checkResetState();
      sysRstN = 1'b1;

      applyStimulus(1'b0, 32'h40000000, 32'h40400000);
      applyStimulus(1'b1, 32'h3F800000, 32'h40400000);
      applyStimulus(1'b1, 32'h3F800000, 32'h00000000);
      applyStimulus(1'b0, 32'h00000000, 32'hFF800000);
      applyStimulus(1'b0, 32'h7F000000, 32'h7F000000);
      applyStimulus(1'b0, 32'h00800000, 32'h00800000);
      applyStimulus(1'b1, 32'hFF800000, 32'h7F800000);
      applyStimulus(1'b1, 32'h40000000, 32'h7FC00001);
      waitDrain();

      respMode = 1;
      applyStimulus(1'b0, 32'hC0400000, 32'h40400000);
      waitDrain();

      respMode = 2;
      applyStimulus(1'b0, 32'h3FC00000, 32'h40000000);
      waitDrain();
      respMode = 0;
      strayCnt++;
      repeat (5) @(negedge sysClk);
      applyStimulus(1'b1, 32'h40E00000, 32'h40000000);
      waitDrain();

      respMode = 2;
      applyStimulus(1'b1, 32'h41200000, 32'h3FC00000);
      repeat (4) @(negedge sysClk);
      sysRstN = 1'b0;
      expQ.delete();
      trigQ.delete();
      vldCycQ.delete();
      #1;
      checkResetState();
      @(negedge sysClk);
      sysRstN = 1'b1;
      respMode = 0;
      strayCnt++;
      repeat (5) @(negedge sysClk);

      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'($urandom), randOperand(), randOperand());
      end
      waitDrain();

      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
